// File: rtl/count_event_pkg.sv
// Shared definitions for the counter event monitor: record kinds and field widths.
// Optional record timestamps are enabled by defining COUNT_EVENT_TS_EN.
package count_event_pkg;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_WRAP  = 2'd1,
    EV_CLEAR = 2'd2,
    EV_JUMP  = 2'd3
  } ev_kind_e;

  localparam int KIND_W = 2;
  localparam int DROP_W = 8;
  localparam int TS_W   = 16;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // Saturating increment for the dropped-record counter.
  function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] cnt);
    return (cnt == DROP_MAX) ? cnt : cnt + DROP_W'(1);
  endfunction

endpackage

// File: rtl/count_event_fifo.sv
// Synchronous FIFO with a registered head output; flush empties it in one cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module count_event_fifo #(
  parameter int DW    = 18,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic [DW-1:0] dout_reg, dout_next;
  logic          do_push, do_pop;

  assign full    = (count_reg == DEPTH_CNT);
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_next = rd_ptr_reg + AW'(do_pop);
    count_next  = count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout_next   = '0;
    if (count_next != '0) begin
      // The only remaining entry is the one being written: forward it.
      if (do_push && count_next == (AW+1)'(1))
        dout_next = din;
      else
        dout_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && do_push)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      dout_reg   <= dout_next;
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/count_event_monitor.sv
// Classifies successive counter samples and queues anomalous steps as event records.
// Define COUNT_EVENT_TS_EN to add a 16-bit cycle timestamp to every record (ev_ts port).
module count_event_monitor
  import count_event_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              smp_en,
  input  logic              clr,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [KIND_W-1:0] ev_kind,
  output logic [WIDTH-1:0]  ev_value,
  output logic [WIDTH-1:0]  ev_prev,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
`ifdef COUNT_EVENT_TS_EN
  ,
  output logic [TS_W-1:0]   ev_ts
`endif
);

  typedef enum logic {ST_INIT, ST_TRACK} state_e;

  localparam logic [WIDTH-1:0] VAL_MAX = '1;
  localparam logic [WIDTH-1:0] VAL_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] VAL_ZERO = '0;
`ifdef COUNT_EVENT_TS_EN
  localparam int REC_W = TS_W + KIND_W + 2*WIDTH;
`else
  localparam int REC_W = KIND_W + 2*WIDTH;
`endif

  state_e            state_reg;
  logic [WIDTH-1:0]  prev_reg;
  logic              overflow_reg;
  logic [DROP_W-1:0] drop_cnt_reg;
  ev_kind_e          kind_c;
  logic              flush, push, pop, drop;
  logic              fifo_full, fifo_empty;
  logic [REC_W-1:0]  rec_in, rec_out;

  assign flush = !reset || clr;

  // First match wins; the wrap test must precede the clear test.
  always_comb begin
    kind_c = EV_NONE;
    if (value == prev_reg)
      kind_c = EV_NONE;
    else if (prev_reg != VAL_MAX && value == prev_reg + VAL_ONE)
      kind_c = EV_NONE;
    else if (prev_reg == VAL_MAX && value == VAL_ZERO)
      kind_c = EV_WRAP;
    else if (value == VAL_ZERO)
      kind_c = EV_CLEAR;
    else
      kind_c = EV_JUMP;
  end

  assign push = smp_en && (state_reg == ST_TRACK) && (kind_c != EV_NONE);
  assign pop  = ev_valid && ev_ready;
  assign drop = push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (flush) begin
      state_reg    <= ST_INIT;
      prev_reg     <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      if (smp_en) begin
        state_reg <= ST_TRACK;
        prev_reg  <= value;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        drop_cnt_reg <= drop_inc(drop_cnt_reg);
      end
    end
  end

`ifdef COUNT_EVENT_TS_EN
  logic [TS_W-1:0] ts_reg;

  always_ff @(posedge clk) begin
    if (flush)
      ts_reg <= '0;
    else
      ts_reg <= ts_reg + TS_W'(1);
  end

  assign rec_in = {ts_reg, kind_c, value, prev_reg};
  assign {ev_ts, ev_kind, ev_value, ev_prev} = rec_out;
`else
  assign rec_in = {kind_c, value, prev_reg};
  assign {ev_kind, ev_value, ev_prev} = rec_out;
`endif

  count_event_fifo #(
    .DW    (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .flush (flush),
    .push  (push),
    .din   (rec_in),
    .pop   (pop),
    .dout  (rec_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: doc/count_event_monitor.md
# count_event_monitor

Downstream consumer of the 8-bit free-running counter output. Samples the counter value every enabled cycle and classifies each step against the previous sample. Anomalous steps (wrap-around, clear to zero, arbitrary jump) are queued as event records in a small FIFO. Records drain over a valid/ready interface to the debug/trace logic. Normal increments and holds produce no record.

## Interface
Parameters:
- WIDTH, 8, counter value width.
- DEPTH, 4, event FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  one clock; reset is synchronous and active-low (0 = reset, sampled on clk).
- value  in  WIDTH  counter output being monitored.
- smp_en  in  1  sample value this cycle.
- clr  in  1  synchronous soft clear (same effect as reset).
- ev_valid  out  1  head record available.
- ev_ready  in  1  consumer accepts head record.
- ev_kind  out  2  head record kind (WRAP=1, CLEAR=2, JUMP=3).
- ev_value  out  WIDTH  sampled value that triggered the record.
- ev_prev  out  WIDTH  previous sample.
- overflow  out  1  sticky: a record was dropped.
- drop_cnt  out  8  dropped-record count, saturates at 255.
- ev_ts  out  16  head record timestamp (only with COUNT_EVENT_TS_EN).

## Operation
- States: INIT (no previous sample) and TRACK.
- INIT: first cycle with smp_en=1 loads prev←value, goes to TRACK, no record.
- TRACK, smp_en=1, classification against prev (mod 2^WIDTH), first match wins:
  - value==prev → HOLD, no record.
  - value==prev+1, prev≠max → INCR, no record.
  - prev==max, value==0 → WRAP.
  - value==0 → CLEAR.
  - otherwise → JUMP.
  - prev←value every sampled cycle, whether or not a record is produced.
- smp_en=0: no classification, prev held.
- Push: record {kind, value, prev[, ts]} written to FIFO.
- Full FIFO with no pop in the same cycle: record dropped, overflow←1, drop_cnt incremented (saturating).
- Full FIFO with a pop in the same cycle: push accepted; occupancy unchanged.
- Pop: occurs when ev_valid && ev_ready.
- Output data: driven from the head entry and held stable while ev_valid=1 && ev_ready=0.
- Empty FIFO: ev_valid=0; ev_kind, ev_value, ev_prev are don't-care (implementation drives 0).
- reset=0 or clr=1 returns to INIT and clears FIFO, overflow, drop_cnt, and ts. clr overrides any push or pop in the same cycle.

## Timing
- Reset values:
  - ev_valid=0.
  - ev_kind=0, ev_value=0, ev_prev=0.
  - overflow=0, drop_cnt=0, ev_ts=0.
  - State=INIT, prev=0.
- Latency: a sample at edge N that produces a record gives ev_valid=1 immediately after edge N (1 cycle). There is no combinational path from value to ev_*.
- Throughput: one push and one pop per cycle.
- ev_ready to ev_valid: no combinational dependency. ev_valid depends only on registered occupancy.
- Reset or clr asserted mid-stream discards queued records. The first sample after release is an INIT load (no CLEAR record, even when value==0).
- Wrap boundary: prev=255, value=0 is WRAP, never CLEAR. prev=255, value=255 is HOLD.

## Configuration
- Macro: COUNT_EVENT_TS_EN.
- Defined:
  - Free-running 16-bit cycle counter, cleared by reset/clr, wraps at 65535→0.
  - Its value at the push edge is stored per record and presented on ev_ts.
- Undefined: no timestamp counter, no ts storage, ev_ts port absent. All other behaviour identical.

## Structure
- Shared package count_event_pkg:
  - Kind encoding constants (EV_NONE=0, EV_WRAP=1, EV_CLEAR=2, EV_JUMP=3).
  - Record field widths.
  - Drop-counter width (8).
- Sub-module count_event_fifo: synchronous FIFO with registered output, parameterised data width and depth, with push/pop, full/empty and flush inputs.
- Classifier and INIT/TRACK state machine live in the top module.

## Test plan
WIDTH=8, DEPTH=4:
- Reset, then smp_en=1 with value 0,1,2,3 → no records; ev_valid stays 0.
- Counter runs 254,255,0 → exactly one WRAP record: value=0, prev=255.
- value 17,18, then 0 (counter reset pulse) → one CLEAR record: value=0, prev=18.
- Six JUMP-producing samples with ev_ready=0 → 4 records queued; overflow=1; drop_cnt=2. Draining yields the first four records in order.
- FIFO full with ev_ready=1 and a push in the same cycle → push accepted, occupancy stays 4, drop_cnt unchanged.
- clr=1 with 3 queued records → ev_valid=0 next cycle. Next sample value=0 produces no record (INIT). With COUNT_EVENT_TS_EN, the next record's ev_ts counts from 0.
